alu_req_sched: RTL and testbench
================================

Name: alu_req_sched

Overview:
- Two-requester front-end scheduler for the shared 4-bit ALU (ALU result/carry registered one clock after alu_valid_in).
- Round-robin arbitration; issues one operation at a time to the ALU and supplies cin from a per-requester carry-flag register.
- Captures the ALU outputs and returns a tagged response through a valid/ready handshake.
- Rejects illegal opcodes without touching the ALU.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU, only 4 is supported.
- CTL_W, 4, opcode width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_ctl  input  CTL_W  ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctl  same as requester 0.
- resp_valid  output  1  response held valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  1  requester index owning the response.
- resp_result  output  WIDTH  ALU result.
- resp_carry  output  1  ALU carry.
- resp_zero  output  1  1 when resp_result==0; computed locally, not taken from the ALU.
- resp_err  output  1  illegal opcode; result/carry/zero forced to 0.
- alu_valid_in  output  1  drives ALU valid_in.
- alu_a, alu_b  output  WIDTH  ALU operands.
- alu_cin  output  1  ALU carry input.
- alu_ctl  output  CTL_W  ALU opcode.
- alu_result  input  WIDTH  ALU registered result.
- alu_carry  input  1  ALU registered carry.

Behaviour:
- Reset (async, active-low):
  - state=IDLE, last_grant=1 (so requester 0 wins first), cflag[0]=cflag[1]=0.
  - All outputs 0, including alu_* and resp_*.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Grant = requester with valid; if both are valid, the one != last_grant.
  - reqN_ready is combinational and asserted only in IDLE for the granted N.
  - On accept: latch a, b, ctl, id; last_grant<=id.
  - Legal opcode (0000-1101): go to ISSUE.
  - Illegal opcode (1110/1111): go to RESP with resp_err=1; no ALU activity.
- ISSUE (1 cycle):
  - alu_valid_in=1; alu_a/b/ctl = latched values; alu_cin=cflag[id].
  - Go to CAPTURE.
- Outside ISSUE: alu_valid_in=0; alu_a/b/ctl/cin hold their last values.
- CAPTURE (1 cycle):
  - Sample alu_result/alu_carry into the response registers.
  - resp_zero <= (alu_result==0); resp_err <= 0.
  - cflag[id] <= alu_carry only for ctl in {0011,0100,0101,0110,1010,1011,1100,1101}; all other ops leave cflag unchanged.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_* stable until resp_valid && resp_ready, then go to IDLE.
  - A new grant is possible in the next cycle, not in the same cycle.
- The ALU valid_out port is not used; the ALU latency is a fixed 1 clock.
- Latency (accept at edge k):
  - Legal op: resp_valid rises after edge k+2.
  - Illegal op: resp_valid rises after edge k.
  - Throughput: at most one op per 4 cycles with resp_ready held high.
- Boundaries:
  - Requests arriving while busy: ready=0 and must be held by the requester.
  - A single valid requester is granted regardless of last_grant.
  - Requester dropping valid without ready: no effect.
  - Reset mid-operation: transaction discarded, no response, cflags cleared.
  - resp_ready high outside RESP: ignored.
- Carry flags are per-requester; one requester never sees the other's carry.

Test Plan:
- Only req0: a=3, b=5, ctl=0011, resp_ready=1 → after edge k+2: resp_valid=1, id=0, result=8, carry=0, zero=0, err=0; cflag[0]=0.
- Carry chain: req0 a=F, b=1, ctl=0011 → result=0, carry=1, zero=1. Then req0 a=0, b=0, ctl=0100 → ISSUE shows alu_cin=1; result=1, carry=0.
- Carry isolation: after the chain step above sets cflag[0]=1, req1 a=0, b=0, ctl=0100 → alu_cin=0, result=0, id=1.
- Contention: both valid every cycle with ops req0 ctl=0000 a=2 and req1 ctl=0000 a=7 → grants alternate 0,1,0,1; resp results 2,7,2,7. Each ready pulses only in IDLE.
- Illegal opcode plus backpressure:
  - req1 ctl=1111 → alu_valid_in never asserts; resp_valid after edge k with err=1, id=1, result=0.
  - Hold resp_ready=0 for 5 cycles → outputs stable, no new grant.
  - Release resp_ready → IDLE next cycle.
- Reset mid-op: assert reset in CAPTURE → immediately resp_valid=0 and alu_valid_in=0. After release, no response appears; a fresh req0 ctl=0100 a=0 b=0 sees alu_cin=0.

Source files
------------

// File: rtl/alu_req_sched.sv
// alu_req_sched: round-robin front end for the shared 4-bit ALU.
// Grants one of two requesters, issues to the ALU and returns a tagged response.
module alu_req_sched #(
  parameter int WIDTH = 4,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTL_W-1:0] req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTL_W-1:0] req1_ctl,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             alu_valid_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       cflag_q, cflag_d;
  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic             id_q, id_d;
  logic             alu_valid_in_q, alu_valid_in_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_carry_q, resp_carry_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_err_q, resp_err_d;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic [CTL_W-1:0] grant_ctl;
  logic             illegal_op;
  logic             carry_op;

  // With both requesters valid the one not served last wins; a lone requester always wins.
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept     = reset && (state_q == IDLE) && (req0_valid || req1_valid);
    grant_a    = grant_id ? req1_a : req0_a;
    grant_b    = grant_id ? req1_b : req0_b;
    grant_ctl  = grant_id ? req1_ctl : req0_ctl;
    illegal_op = (grant_ctl == 4'b1110) || (grant_ctl == 4'b1111);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    case (ctl_q)
      4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13: carry_op = 1'b1;
      default:                                            carry_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cflag_d        = cflag_q;
    ctl_d          = ctl_q;
    id_d           = id_q;
    alu_valid_in_d = 1'b0;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_cin_d      = alu_cin_q;
    alu_ctl_d      = alu_ctl_q;
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;
    resp_result_d  = resp_result_q;
    resp_carry_d   = resp_carry_q;
    resp_zero_d    = resp_zero_q;
    resp_err_d     = resp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d         = grant_id;
          ctl_d        = grant_ctl;
          last_grant_d = grant_id;
          if (illegal_op) begin
            // Illegal opcodes never reach the ALU; answer straight away with an error.
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_id_d     = grant_id;
            resp_result_d = '0;
            resp_carry_d  = 1'b0;
            resp_zero_d   = 1'b0;
            resp_err_d    = 1'b1;
          end else begin
            state_d        = ISSUE;
            alu_valid_in_d = 1'b1;
            alu_a_d        = grant_a;
            alu_b_d        = grant_b;
            alu_ctl_d      = grant_ctl;
            alu_cin_d      = cflag_q[grant_id];
          end
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_id_d     = id_q;
        resp_result_d = alu_result;
        resp_carry_d  = alu_carry;
        resp_zero_d   = (alu_result == '0);
        resp_err_d    = 1'b0;
        if (carry_op) begin
          cflag_d[id_q] = alu_carry;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      cflag_q        <= '0;
      ctl_q          <= '0;
      id_q           <= 1'b0;
      alu_valid_in_q <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_cin_q      <= 1'b0;
      alu_ctl_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_result_q  <= '0;
      resp_carry_q   <= 1'b0;
      resp_zero_q    <= 1'b0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cflag_q        <= cflag_d;
      ctl_q          <= ctl_d;
      id_q           <= id_d;
      alu_valid_in_q <= alu_valid_in_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_cin_q      <= alu_cin_d;
      alu_ctl_q      <= alu_ctl_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_result_q  <= resp_result_d;
      resp_carry_q   <= resp_carry_d;
      resp_zero_q    <= resp_zero_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign alu_valid_in = alu_valid_in_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cin      = alu_cin_q;
  assign alu_ctl      = alu_ctl_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_result  = resp_result_q;
  assign resp_carry   = resp_carry_q;
  assign resp_zero    = resp_zero_q;
  assign resp_err     = resp_err_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: directed bench for alu_req_sched with a stand-in 1-cycle ALU
// and a transaction-level reference model compared every cycle.
module tb_alu_req_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req0_ctl = '0;
  logic [3:0] req1_a = '0, req1_b = '0, req1_ctl = '0;
  logic       resp_valid, resp_ready = 1'b0, resp_id;
  logic [3:0] resp_result;
  logic       resp_carry, resp_zero, resp_err;
  logic       alu_valid_in, alu_cin;
  logic [3:0] alu_a, alu_b, alu_ctl;
  logic [3:0] alu_result = '0;
  logic       alu_carry = 1'b0;

  int checks = 0;
  int errors = 0;

  alu_req_sched #(.WIDTH(4), .CTL_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_carry(resp_carry), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // Stand-in ALU behaviour: 0000 passes A, 0011 adds, 0100 adds with carry-in.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [3:0] ctl);
    case (ctl)
      4'b0000: alu_fn = {1'b0, a};
      4'b0011: alu_fn = {1'b0, a} + {1'b0, b};
      4'b0100: alu_fn = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      default: alu_fn = {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_valid_in) {alu_carry, alu_result} <= alu_fn(alu_a, alu_b, alu_cin, alu_ctl);
  end

  // Reference model: one outstanding transaction, tracked by its age in edges since acceptance.
  logic       m_busy = 1'b0, m_last = 1'b1, m_legal = 1'b0;
  logic [1:0] m_cflag = '0;
  int         m_age = 0;
  logic       m_id = 1'b0;
  logic [3:0] m_res = '0;
  logic       m_carry = 1'b0, m_err = 1'b0;
  logic [3:0] m_alu_a = '0, m_alu_b = '0, m_alu_ctl = '0;
  logic       m_alu_cin = 1'b0;

  logic       m_gid, m_resp_vis, m_glegal;
  logic [3:0] m_ga, m_gb, m_gctl;
  logic [4:0] m_fn;
  assign m_gid      = (req0_valid && req1_valid) ? !m_last : req1_valid;
  assign m_ga       = m_gid ? req1_a : req0_a;
  assign m_gb       = m_gid ? req1_b : req0_b;
  assign m_gctl     = m_gid ? req1_ctl : req0_ctl;
  assign m_glegal   = m_gctl < 4'd14;
  assign m_fn       = alu_fn(m_ga, m_gb, m_cflag[m_gid], m_gctl);
  assign m_resp_vis = m_busy && (!m_legal || m_age >= 2);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_last <= 1'b1; m_cflag <= '0; m_age <= 0;
      m_alu_a <= '0; m_alu_b <= '0; m_alu_ctl <= '0; m_alu_cin <= 1'b0;
      m_id <= 1'b0; m_res <= '0; m_carry <= 1'b0; m_err <= 1'b0; m_legal <= 1'b0;
    end else if (m_busy) begin
      if (m_resp_vis && resp_ready) m_busy <= 1'b0;
      else m_age <= m_age + 1;
    end else if (req0_valid || req1_valid) begin
      m_busy  <= 1'b1;
      m_age   <= 0;
      m_id    <= m_gid;
      m_last  <= m_gid;
      m_legal <= m_glegal;
      m_err   <= !m_glegal;
      m_res   <= m_glegal ? m_fn[3:0] : 4'd0;
      m_carry <= m_glegal ? m_fn[4] : 1'b0;
      if (m_glegal) begin
        m_alu_a <= m_ga; m_alu_b <= m_gb; m_alu_ctl <= m_gctl; m_alu_cin <= m_cflag[m_gid];
        if (m_gctl inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13})
          m_cflag[m_gid] <= m_fn[4];
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_req0_ready", req0_ready, reset && !m_busy && (req0_valid || req1_valid) && !m_gid);
    checkOutput("model_req1_ready", req1_ready, reset && !m_busy && (req0_valid || req1_valid) && m_gid);
    checkOutput("model_alu_valid_in", alu_valid_in, m_busy && m_legal && m_age == 0);
    checkOutput("model_alu_a", alu_a, m_alu_a);
    checkOutput("model_alu_b", alu_b, m_alu_b);
    checkOutput("model_alu_ctl", alu_ctl, m_alu_ctl);
    checkOutput("model_alu_cin", alu_cin, m_alu_cin);
    checkOutput("model_resp_valid", resp_valid, m_resp_vis);
    if (m_resp_vis) begin
      checkOutput("model_resp_id", resp_id, m_id);
      checkOutput("model_resp_result", resp_result, m_res);
      checkOutput("model_resp_carry", resp_carry, m_carry);
      checkOutput("model_resp_zero", resp_zero, !m_err && m_res == 4'd0);
      checkOutput("model_resp_err", resp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] c0,
                               input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [3:0] c1,
                               input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctl = c1;
    resp_ready = rr;
  endtask

  task automatic idleInputs(input logic rr);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, rr);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  int seen_id[4];
  int seen_res[4];
  int exp_id[4]  = '{0, 1, 0, 1};
  int exp_res[4] = '{2, 7, 2, 7};
  int got;

  initial begin
    #2 reset = 1'b0;
    tick();
    checkOutput("reset_resp_valid", resp_valid, 0);
    checkOutput("reset_alu_valid_in", alu_valid_in, 0);
    checkOutput("reset_resp_result", resp_result, 0);
    tick();
    reset = 1'b1;
    tick();

    // Lone requester 0: 3 + 5.
    applyStimulus(1'b1, 4'd3, 4'd5, 4'b0011, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick();
    idleInputs(1'b1);
    checkOutput("add_alu_valid_in", alu_valid_in, 1);
    checkOutput("add_alu_a", alu_a, 3);
    tick();
    checkOutput("add_resp_early", resp_valid, 0);
    tick();
    checkOutput("add_resp_valid", resp_valid, 1);
    checkOutput("add_resp_id", resp_id, 0);
    checkOutput("add_resp_result", resp_result, 8);
    checkOutput("add_resp_carry", resp_carry, 0);
    checkOutput("add_resp_zero", resp_zero, 0);
    checkOutput("add_resp_err", resp_err, 0);
    tick();

    // Carry chain on requester 0, then isolation check on requester 1.
    applyStimulus(1'b1, 4'hF, 4'd1, 4'b0011, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick(); idleInputs(1'b1); tick(); tick();
    checkOutput("chain1_result", resp_result, 0);
    checkOutput("chain1_carry", resp_carry, 1);
    checkOutput("chain1_zero", resp_zero, 1);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd0, 4'b0100, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick(); idleInputs(1'b1);
    checkOutput("chain2_alu_cin", alu_cin, 1);
    tick(); tick();
    checkOutput("chain2_result", resp_result, 1);
    checkOutput("chain2_carry", resp_carry, 0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 4'b0100, 1'b1);
    tick(); idleInputs(1'b1);
    checkOutput("iso_alu_cin", alu_cin, 0);
    tick(); tick();
    checkOutput("iso_resp_id", resp_id, 1);
    checkOutput("iso_result", resp_result, 0);
    tick();

    // Contention from a fresh reset: grants must alternate starting with requester 0.
    pulseReset();
    applyStimulus(1'b1, 4'd2, 4'd0, 4'b0000, 1'b1, 4'd7, 4'd0, 4'b0000, 1'b1);
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      tick();
      if (resp_valid && resp_ready) begin
        seen_id[got]  = resp_id;
        seen_res[got] = resp_result;
        got++;
      end
    end
    idleInputs(1'b1);
    checkOutput("contention_count", got, 4);
    for (int i = 0; i < got; i++) begin
      checkOutput("contention_id", seen_id[i], exp_id[i]);
      checkOutput("contention_result", seen_res[i], exp_res[i]);
    end
    tick();

    // Illegal opcode with the response held back by resp_ready.
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd6, 4'b1111, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd1, 4'd1, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    checkOutput("illegal_resp_valid", resp_valid, 1);
    checkOutput("illegal_resp_err", resp_err, 1);
    checkOutput("illegal_resp_id", resp_id, 1);
    checkOutput("illegal_resp_result", resp_result, 0);
    checkOutput("illegal_alu_valid_in", alu_valid_in, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_resp_valid", resp_valid, 1);
      checkOutput("hold_req0_ready", req0_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    checkOutput("release_resp_valid", resp_valid, 0);
    checkOutput("release_req0_ready", req0_ready, 1);
    tick();
    idleInputs(1'b1);
    checkOutput("after_release_alu_valid_in", alu_valid_in, 1);
    tick(); tick();
    checkOutput("after_release_result", resp_result, 1);
    tick();

    // Set cflag[0], then reset in the middle of a second op.
    applyStimulus(1'b1, 4'hF, 4'd1, 4'b0011, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick(); idleInputs(1'b1); tick(); tick(); tick();
    applyStimulus(1'b1, 4'hF, 4'd1, 4'b0011, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick(); idleInputs(1'b1);
    tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_resp_valid", resp_valid, 0);
    checkOutput("midreset_alu_valid_in", alu_valid_in, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_reset_no_resp", resp_valid, 0);
    end
    applyStimulus(1'b1, 4'd0, 4'd0, 4'b0100, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick(); idleInputs(1'b1);
    checkOutput("post_reset_alu_cin", alu_cin, 0);
    tick(); tick();
    checkOutput("post_reset_result", resp_result, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
